// File: rtl/aes_out_monitor.sv
`default_nettype none
// =============================================================================
// Module   : aes_out_monitor
// Brief    : Latency-matched valid tracker, completion counter, signature and
//            output FIFO for the pipelined aes_128 core.
//            Optional signature logic is enabled by AES_MON_SIGNATURE_EN.
// Revision : 1.0 - initial release
// =============================================================================
module aes_out_monitor #(
   parameter int DATA_WIDTH  = 128,
   parameter int LATENCY     = 21,
   parameter int FIFO_DEPTH  = 4,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] num_tests,
   input  logic                   in_valid,
   input  logic [DATA_WIDTH-1:0]  aes_out,
   output logic                   out_valid,
   output logic [DATA_WIDTH-1:0]  out_data,
   input  logic                   out_ready,
   output logic [COUNT_WIDTH-1:0] done_count,
   output logic [DATA_WIDTH-1:0]  signature,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] target_q, target_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [LATENCY-1:0]     delay_q, delay_d;
   logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;
   logic                   overflow_q, overflow_d;
   logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];

   logic tap, accept, load_in, fifo_empty, fifo_full, pop, push;

   assign tap        = delay_q[LATENCY-1];
   assign accept     = tap && (state_q == ST_RUN) && (count_q < target_q) && !start;
   assign load_in    = in_valid && (state_q == ST_RUN);
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign pop        = !fifo_empty && out_ready && !start;
   // A pop frees the slot on the same edge, so a full FIFO still takes the push.
   assign push       = accept && (!fifo_full || pop);

   generate
      if (LATENCY == 1) begin : g_delay_1
         assign delay_d[0] = start ? 1'b0 : load_in;
      end else begin : g_delay_n
         assign delay_d = start ? '0 : {delay_q[LATENCY-2:0], load_in};
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (start) begin
         target_d   = num_tests;
         count_d    = '0;
         overflow_d = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         state_d    = (num_tests == '0) ? ST_DONE : ST_RUN;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
         end
         if (accept) begin
            count_d = count_q + COUNT_WIDTH'(1);
            if (fifo_full && !pop) begin
               overflow_d = 1'b1;
            end
            if (count_d == target_q) begin
               state_d = ST_DONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         target_q   <= '0;
         count_q    <= '0;
         delay_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         count_q    <= count_d;
         delay_q    <= delay_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: out_data is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= aes_out;
      end
   end

`ifdef AES_MON_SIGNATURE_EN
   logic [DATA_WIDTH-1:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (start) begin
         sig_d = '0;
      end else if (accept) begin
         sig_d = {sig_q[DATA_WIDTH-2:0], sig_q[DATA_WIDTH-1]} ^ aes_out;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign signature = sig_q;
`else
   assign signature = '0;
`endif

   assign out_valid  = !fifo_empty;
   assign out_data   = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
   assign done_count = count_q;
   assign busy       = (state_q == ST_RUN);
   assign done       = (state_q == ST_DONE);
   assign overflow   = overflow_q;

endmodule
`default_nettype wire
